led_array_scanner: RTL and testbench
====================================

# led_array_scanner

Time-multiplexing controller for the N×N LED array driver. It steps the driver's column select `x` through 0..N-1 with a programmable dwell per column. A blanking interval at each column change suppresses ghosting. A one-deep frame buffer with a valid/ready handshake guarantees that a new `cells` image only reaches the driver at a frame boundary, so no frame is ever shown torn. It sits between the game-of-life state register, which produces frames, and `led_array_driver`, which receives `ena`, `x` and `cells`.

## Interface
- `N`, 5, array dimension (N×N cells, N columns scanned)
- `BLANK_TICKS`, 2, clocks per column with `ena`=0 (0 = no blanking)
- `DRIVE_TICKS`, 1000, clocks per column with `ena`=1 (must be ≥1)

- `clk` input 1: system clock, all logic on rising edge
- `rst` input 1: asynchronous, active-high reset
- `run` input 1: scan enable; 0 forces IDLE
- `frame` input N*N: next image, bit N*j+i = cell (i,j)
- `frame_valid` input 1: `frame` is valid
- `frame_ready` output 1: pending buffer empty, can accept a frame
- `ena` output 1: driver enable
- `x` output $clog2(N)+1: active column index, 0..N-1
- `cells` output N*N: image currently displayed
- `frame_done` output 1: one-cycle pulse at each frame boundary

## Operation
- States:
  - IDLE: `ena`=0, `x`=0, dwell counter 0.
  - BLANK: `ena`=0, counting `BLANK_TICKS`.
  - DRIVE: `ena`=1, counting `DRIVE_TICKS`.
- IDLE → BLANK when `run`=1. If `BLANK_TICKS`=0, IDLE → DRIVE directly.
- BLANK → DRIVE after `BLANK_TICKS` cycles in BLANK.
- DRIVE, end of dwell:
  - If `x`<N-1: `x`++ and go to BLANK (or DRIVE if `BLANK_TICKS`=0).
  - If `x`=N-1: frame boundary. `x`←0 and the next state is the same as for `x`<N-1.
- Any state → IDLE on the cycle after `run`=0, with `x`←0 and the counter cleared. `cells` and the pending buffer are retained.
- Dwell counter width: $clog2(max(BLANK_TICKS,DRIVE_TICKS)+1). It counts 0..T-1 and then clears.
- Frame buffer handshake:
  - A transfer occurs on a cycle where `frame_valid`=1 and `frame_ready`=1. `frame` is copied into `pending`, `pending_full`←1 and `frame_ready`←0.
  - `frame_ready` = !`pending_full`. It is registered and does not depend combinationally on `frame_valid`.
- Frame boundary, with `pending_full`=1: `cells`←`pending`, `pending_full`←0, and `frame_ready` returns to 1 the next cycle.
- Frame boundary, with `pending_full`=0: `cells` unchanged.
- Transfer on the same cycle as a boundary with `pending_full`=0: the frame goes to `pending` and appears at the following boundary.
- In IDLE with `pending_full`=1: `cells`←`pending` immediately, so the first frame after `run` rises is current.
- `frame_done` pulses on the cycle the boundary transition is registered, whether or not a swap occurs.

## Timing
- Reset values: `ena`=0, `x`=0, `cells`=0, `frame_ready`=1, `frame_done`=0, state IDLE, `pending_full`=0.
- Reset may assert mid-scan. The clear is immediate and asynchronous, and the scan restarts from IDLE after reset releases.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `run` rise at edge k: BLANK is entered at edge k+1. `ena` rises at edge k+1+`BLANK_TICKS`.
- Column period P = `BLANK_TICKS`+`DRIVE_TICKS` cycles. Frame period = N·P cycles.
- `x` changes only on a blank/drive transition into column-change BLANK, never while `ena`=1. `ena` is high exactly `DRIVE_TICKS` consecutive cycles per column.
- Throughput is at most one accepted frame per displayed frame. Back-to-back producers are stalled via `frame_ready`.

## Test plan
Use N=5, `BLANK_TICKS`=2, `DRIVE_TICKS`=4.

1. Reset, then `run`=1 for 60 cycles.
   - `x` sequence 0,1,2,3,4,0,1… with each value held 6 cycles.
   - `ena` pattern per column: 2 low, then 4 high.
   - `frame_done` pulses every 30 cycles.
   - `ena`=1 never coincides with an `x` change.
2. In IDLE, push `frame`=25'h1FFFFFF, then raise `run`.
   - `cells`=25'h1FFFFFF before the first `ena`.
   - `frame_ready` is 0 for exactly 1 cycle after the transfer.
3. Mid-frame at `x`=2, push `frame`=25'h0000001.
   - `cells` unchanged until `frame_done`, then 25'h0000001.
   - A second push made while `frame_ready`=0 is held off until after the swap.
4. Assert `frame_valid` on the boundary cycle with the buffer empty.
   - The frame appears at the next boundary, 30 cycles later, not the current one.
5. Drop `run` while `x`=3 and `ena`=1.
   - Next cycle: `ena`=0, `x`=0.
   - Re-raise `run`: the scan restarts at column 0 with a full 2-cycle blank.
6. Assert `rst` asynchronously mid-DRIVE at `x`=4 with `pending_full`=1.
   - All outputs go to reset values without a clock edge; `frame_ready`=1 and `cells`=0.
   - Repeat with `BLANK_TICKS`=0: `ena` stays 1 continuously across all column changes.

Source files
------------

// File: rtl/led_array_scanner_if.sv
// rtl/led_array_scanner_if.sv - frame producer and LED driver signal bundle for the scanner
interface led_array_scanner_if #(
  parameter int N = 5
);
  localparam int XW = $clog2(N) + 1;

  logic            run;
  logic [N*N-1:0]  frame;
  logic            frame_valid;
  logic            frame_ready;
  logic            ena;
  logic [XW-1:0]   x;
  logic [N*N-1:0]  cells;
  logic            frame_done;

  modport master (
    output run, frame, frame_valid,
    input  frame_ready, ena, x, cells, frame_done
  );

  modport slave (
    input  run, frame, frame_valid,
    output frame_ready, ena, x, cells, frame_done
  );
endinterface

// File: rtl/led_array_scanner.sv
// rtl/led_array_scanner.sv - column scan sequencer with tear-free frame-boundary image swap
module led_array_scanner #(
  parameter int N           = 5,
  parameter int BLANK_TICKS = 2,
  parameter int DRIVE_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  led_array_scanner_if.slave bus
);
  localparam int NN   = N * N;
  localparam int XW   = $clog2(N) + 1;
  localparam int TMAX = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int CW   = $clog2(TMAX + 1);

  // Last count value of each dwell; the blank value is unused when blanking is disabled.
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_TICKS - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state_q, state_d, next_col;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic            ena_q, ena_d;
  logic [NN-1:0]   cells_q, cells_d;
  logic [NN-1:0]   pending_q, pending_d;
  logic            pending_full_q, pending_full_d;
  logic            frame_ready_q, frame_ready_d;
  logic            frame_done_q, frame_done_d;
  logic            boundary;

  // Scan sequencing plus the one-deep pending buffer; swaps only at a frame boundary or while idle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    cells_d        = cells_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    boundary       = 1'b0;

    // Every new column starts with blanking unless blanking is disabled.
    if (BLANK_TICKS == 0) next_col = DRIVE;
    else                  next_col = BLANK;

    if (!bus.run) begin
      state_d = IDLE;
      cnt_d   = '0;
      x_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = next_col;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = next_col;
            cnt_d   = '0;
            if (x_q == X_LAST) begin
              x_d      = '0;
              boundary = 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          x_d     = '0;
        end
      endcase
    end

    // Idle swap makes a frame loaded before run rises visible from the first column.
    if ((boundary || state_q == IDLE) && pending_full_q) begin
      cells_d        = pending_q;
      pending_full_d = 1'b0;
    end

    // Ready is only high with an empty buffer, so a transfer never collides with a swap.
    if (bus.frame_valid && frame_ready_q) begin
      pending_d      = bus.frame;
      pending_full_d = 1'b1;
    end

    frame_ready_d = !pending_full_d;
    frame_done_d  = boundary;
    ena_d         = (state_d == DRIVE);
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      x_q            <= '0;
      ena_q          <= 1'b0;
      cells_q        <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_ready_q  <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      ena_q          <= ena_d;
      cells_q        <= cells_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      frame_ready_q  <= frame_ready_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.ena         = ena_q;
  assign bus.x           = x_q;
  assign bus.cells       = cells_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_led_array_scanner.sv
// tb/tb_led_array_scanner.sv - scoreboard bench for the LED column scanner
module tb_led_array_scanner;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [24:0] cells;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp0_q[$];
  ev_t ev_a;
  ev_t ev_b;

  led_array_scanner_if #(.N(5)) bus ();
  led_array_scanner_if #(.N(5)) bus0 ();

  led_array_scanner #(.N(5), .BLANK_TICKS(2), .DRIVE_TICKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_array_scanner #(.N(5), .BLANK_TICKS(0), .DRIVE_TICKS(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("step_to_reached", cyc, target);
  endtask

  // Scoreboard monitors: each frame_done pulse must match the next expected image and cycle.
  always @(negedge clk) begin
    if (!rst && bus.frame_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done_a: got pulse expected none (cyc %0d)", cyc);
      end else begin
        ev_a = exp_q.pop_front();
        chk("frame_done_cells_a", {7'd0, bus.cells}, {7'd0, ev_a.cells});
        chk("frame_done_cyc_a", cyc, ev_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus0.frame_done) begin
      if (exp0_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done_b: got pulse expected none (cyc %0d)", cyc);
      end else begin
        ev_b = exp0_q.pop_front();
        chk("frame_done_cells_b", {7'd0, bus0.cells}, {7'd0, ev_b.cells});
        chk("frame_done_cyc_b", cyc, ev_b.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c2;
    int c3;
    int c4;
    logic [3:0] prev_x;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.run = 1'b0;  bus.frame = '0;  bus.frame_valid = 1'b0;
    bus0.run = 1'b0; bus0.frame = '0; bus0.frame_valid = 1'b0;

    step();
    step();
    chk("rst_ena", bus.ena, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_cells", bus.cells, 0);
    chk("rst_ready", bus.frame_ready, 1);
    chk("rst_done", bus.frame_done, 0);
    rst = 1'b0;
    step();

    // Free-running scan with no frames offered.
    bus.run = 1'b1;
    c0 = cyc;
    exp_q.push_back('{25'h0, c0 + 31});
    exp_q.push_back('{25'h0, c0 + 61});
    prev_x = 4'd0;
    for (int t = 1; t <= 61; t++) begin
      step();
      chk("t1_x", bus.x, ((t - 1) / 6) % 5);
      chk("t1_ena", bus.ena, (((t - 1) % 6) >= 2) ? 1 : 0);
      if (bus.x != prev_x) chk("t1_ena_at_xchg", bus.ena, 0);
      prev_x = bus.x;
    end

    // Load a frame while idle; it becomes current before the first drive.
    bus.run = 1'b0;
    step();
    chk("t2_idle_ena", bus.ena, 0);
    chk("t2_idle_x", bus.x, 0);
    chk("t2_ready_before", bus.frame_ready, 1);
    bus.frame_valid = 1'b1;
    bus.frame = 25'h1FFFFFF;
    step();
    chk("t2_ready_low", bus.frame_ready, 0);
    bus.frame_valid = 1'b0;
    step();
    chk("t2_ready_back", bus.frame_ready, 1);
    chk("t2_cells_idle", bus.cells, 32'h1FFFFFF);
    bus.run = 1'b1;
    c2 = cyc;
    step_to(c2 + 2);
    chk("t2_cells_pre_ena", bus.cells, 32'h1FFFFFF);
    chk("t2_ena_blank", bus.ena, 0);
    step_to(c2 + 3);
    chk("t2_ena_rise", bus.ena, 1);

    // Mid-frame push, then a second push stalled until the swap.
    step_to(c2 + 13);
    chk("t3_x2", bus.x, 2);
    exp_q.push_back('{25'h0000001, c2 + 31});
    bus.frame_valid = 1'b1;
    bus.frame = 25'h0000001;
    step();
    chk("t3_ready_low", bus.frame_ready, 0);
    bus.frame = 25'h0ABCDEF;
    step_to(c2 + 20);
    chk("t3_cells_hold_mid", bus.cells, 32'h1FFFFFF);
    step_to(c2 + 30);
    chk("t3_cells_hold_end", bus.cells, 32'h1FFFFFF);
    chk("t3_ready_still_low", bus.frame_ready, 0);
    step_to(c2 + 31);
    chk("t3_ready_after_swap", bus.frame_ready, 1);
    step();
    chk("t3_second_taken", bus.frame_ready, 0);
    bus.frame_valid = 1'b0;
    exp_q.push_back('{25'h0ABCDEF, c2 + 61});

    // Transfer on the boundary cycle with the buffer empty.
    step_to(c2 + 90);
    chk("t4_x4", bus.x, 4);
    chk("t4_ena", bus.ena, 1);
    chk("t4_ready", bus.frame_ready, 1);
    exp_q.push_back('{25'h0ABCDEF, c2 + 91});
    exp_q.push_back('{25'h1234567, c2 + 121});
    bus.frame_valid = 1'b1;
    bus.frame = 25'h1234567;
    step();
    chk("t4_ready_low", bus.frame_ready, 0);
    bus.frame_valid = 1'b0;
    step_to(c2 + 120);
    chk("t4_cells_not_yet", bus.cells, 32'h0ABCDEF);
    step_to(c2 + 122);
    chk("t4_ready_after", bus.frame_ready, 1);

    // Drop run mid-drive at column 3, then restart.
    step_to(c2 + 142);
    chk("t5_x3", bus.x, 3);
    chk("t5_ena", bus.ena, 1);
    bus.run = 1'b0;
    step();
    chk("t5_stop_ena", bus.ena, 0);
    chk("t5_stop_x", bus.x, 0);
    step();
    bus.run = 1'b1;
    c3 = cyc;
    step_to(c3 + 1);
    chk("t5_re_x", bus.x, 0);
    chk("t5_re_ena1", bus.ena, 0);
    chk("t5_cells_kept", bus.cells, 32'h1234567);
    step_to(c3 + 2);
    chk("t5_re_ena2", bus.ena, 0);
    step_to(c3 + 3);
    chk("t5_re_ena3", bus.ena, 1);
    chk("t5_re_x3", bus.x, 0);

    // Async reset mid-drive at column 4 with the buffer full.
    step_to(c3 + 5);
    chk("t6_ready_pre", bus.frame_ready, 1);
    bus.frame_valid = 1'b1;
    bus.frame = 25'h0F0F0F0;
    step();
    bus.frame_valid = 1'b0;
    chk("t6_pending_full", bus.frame_ready, 0);
    step_to(c3 + 28);
    chk("t6_x4", bus.x, 4);
    chk("t6_ena", bus.ena, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_ena", bus.ena, 0);
    chk("t6_rst_x", bus.x, 0);
    chk("t6_rst_cells", bus.cells, 0);
    chk("t6_rst_ready", bus.frame_ready, 1);
    chk("t6_rst_done", bus.frame_done, 0);
    bus.run = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("t6_post_cells", bus.cells, 0);
    chk("t6_post_ready", bus.frame_ready, 1);

    // No-blank variant: ena stays high across every column change.
    bus0.run = 1'b1;
    c4 = cyc;
    exp0_q.push_back('{25'h0000155, c4 + 21});
    for (int t = 1; t <= 38; t++) begin
      step();
      chk("t6b_ena", bus0.ena, 1);
      chk("t6b_x", bus0.x, ((t - 1) / 4) % 5);
      if (t == 2 || t == 22) begin
        bus0.frame_valid = 1'b1;
        bus0.frame = (t == 2) ? 25'h0000155 : 25'h00000AA;
      end else begin
        bus0.frame_valid = 1'b0;
      end
    end
    chk("t6b_pending_full", bus0.frame_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6b_rst_ena", bus0.ena, 0);
    chk("t6b_rst_x", bus0.x, 0);
    chk("t6b_rst_cells", bus0.cells, 0);
    chk("t6b_rst_ready", bus0.frame_ready, 1);
    bus0.run = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();

    chk("scoreboard_a_drained", exp_q.size(), 0);
    chk("scoreboard_b_drained", exp0_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
